// File: rtl/mfun_pkg.sv
// mfun_pkg: shared state encoding, generator width and parameter defaults for the chip sequencer.
package mfun_pkg;
    typedef enum logic [1:0] {IDLE, LOADED, RUN} state_t;
    localparam int STATE_W = 4;
    localparam int LEN_W_DEF = 8;
    localparam int DIV_W_DEF = 5;
endpackage

// File: rtl/mseq_step.sv
// mseq_step: one shift-right step of the 4-bit generator with tap-selected XOR feedback.
module mseq_step
    import mfun_pkg::*;
(
    input  logic [STATE_W-1:0] fase,
    input  logic [STATE_W-1:0] taps,
    output logic [STATE_W-1:0] next_fase,
    output logic               fb
);
    always_comb begin
        fb = ^(fase & taps);
        next_fase = {fb, fase[STATE_W-1:1]};
    end
endmodule

// File: rtl/mseq_ctrl.sv
// mseq_ctrl: configurable chip sequencer with handshake config, clock divider,
// run length control and lockup detection.
module mseq_ctrl
    import mfun_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [STATE_W-1:0] cfg_seed,
    input  logic [STATE_W-1:0] cfg_taps,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               start,
    input  logic               stop,
    output logic               chip,
    output logic               chip_valid,
    output logic [STATE_W-1:0] fase,
    output logic               busy,
    output logic               done,
    output logic               period_wrap,
    output logic               err
);
    state_t state, state_nx;
    logic [STATE_W-1:0] seed, taps, next_fase;
    logic [DIV_W-1:0] div, div_cnt;
    logic [LEN_W-1:0] len, cnt;
    logic fb, cfg_ok, cfg_bad, go, step, last, lock;

    mseq_step u_step (
        .fase(fase),
        .taps(taps),
        .next_fase(next_fase),
        .fb(fb)
    );

    always_comb begin
        cfg_ready = state != RUN;
        busy = state == RUN;
        cfg_ok = cfg_valid && cfg_ready && cfg_seed != '0;
        cfg_bad = cfg_valid && cfg_ready && cfg_seed == '0;
        go = start && state == LOADED;
        step = busy && !stop && div_cnt == div;
        last = step && len != '0 && cnt == len - LEN_W'(1);
        // the updated state is zero exactly when feedback and the surviving bits are all zero
        lock = step && !fb && fase[STATE_W-1:1] == '0;
        state_nx = lock ? IDLE :
                   (busy && stop) || last ? LOADED :
                   go ? RUN :
                   cfg_ok ? LOADED : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed <= '0;
            taps <= '0;
            div <= '0;
            len <= '0;
            div_cnt <= '0;
            cnt <= '0;
            fase <= '0;
            chip <= 1'b0;
            chip_valid <= 1'b0;
            done <= 1'b0;
            period_wrap <= 1'b0;
            err <= 1'b0;
        end else begin
            chip_valid <= step;
            done <= last;
            period_wrap <= step && next_fase == seed;
            err <= lock || cfg_bad;
            if (step) chip <= fase[0];
            if (cfg_ok) begin
                seed <= cfg_seed;
                taps <= cfg_taps;
                div <= cfg_div;
                len <= cfg_len;
            end
            if (go) begin
                fase <= seed;
                div_cnt <= '0;
                cnt <= '0;
            end else if (busy && !stop) begin
                div_cnt <= step ? '0 : div_cnt + DIV_W'(1);
                if (step) begin
                    fase <= next_fase;
                    cnt <= &cnt ? cnt : cnt + LEN_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mseq_ctrl.sv
// tb_mseq_ctrl: directed self-checking bench for the chip sequencer.
module tb_mseq_ctrl;
    logic clk = 0, rst = 1, cfg_valid = 0, start = 0, stop = 0;
    logic [3:0] cfg_seed = 0, cfg_taps = 0;
    logic [4:0] cfg_div = 0;
    logic [7:0] cfg_len = 0;
    logic cfg_ready, chip, chip_valid, busy, done, period_wrap, err;
    logic [3:0] fase;
    int errors = 0, checks = 0;

    typedef struct {
        logic       chip;
        logic [3:0] fase;
    } vec_t;
    vec_t tab[15];

    mseq_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_div(cfg_div), .cfg_len(cfg_len),
        .start(start), .stop(stop), .chip(chip), .chip_valid(chip_valid), .fase(fase),
        .busy(busy), .done(done), .period_wrap(period_wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] status();
        return {cfg_ready, busy, chip_valid, chip, done, period_wrap, err, fase};
    endfunction

    task automatic configure(input logic [3:0] s, input logic [3:0] t, input logic [4:0] d, input logic [7:0] l);
        cfg_seed = s; cfg_taps = t; cfg_div = d; cfg_len = l; cfg_valid = 1;
        tick();
        cfg_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        tab[0]  = '{1'b1, 4'b1000}; tab[1]  = '{1'b0, 4'b0100}; tab[2]  = '{1'b0, 4'b0010};
        tab[3]  = '{1'b0, 4'b1001}; tab[4]  = '{1'b1, 4'b1100}; tab[5]  = '{1'b0, 4'b0110};
        tab[6]  = '{1'b0, 4'b1011}; tab[7]  = '{1'b1, 4'b0101}; tab[8]  = '{1'b1, 4'b1010};
        tab[9]  = '{1'b0, 4'b1101}; tab[10] = '{1'b1, 4'b1110}; tab[11] = '{1'b0, 4'b1111};
        tab[12] = '{1'b1, 4'b0111}; tab[13] = '{1'b1, 4'b0011}; tab[14] = '{1'b1, 4'b0001};

        do_reset();
        chk("reset_status", status(), 11'b1_0_0_0_0_0_0_0000);

        // full-period run, div=0, len=15
        configure(4'b0001, 4'b0011, 5'd0, 8'd15);
        chk("cfg_loaded", status(), 11'b1_0_0_0_0_0_0_0000);
        pulse_start();
        chk("start_run", status(), 11'b0_1_0_0_0_0_0_0001);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("seq_%0d", i), status(),
                {i == 14, i != 14, 1'b1, tab[i].chip, i == 14, i == 14, 1'b0, tab[i].fase});
        end
        tick();
        chk("after_done", status(), 11'b1_0_0_1_0_0_0_0001);

        // divider 3, continuous; stop on a step edge
        configure(4'b0001, 4'b0011, 5'd3, 8'd0);
        pulse_start();
        chk("div_start_busy", busy, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("div_cv_%0d", k), chip_valid, (k % 4) == 0);
            if (k == 4) chk("div_chip_4", chip, 1);
            if (k == 8) chk("div_chip_8", chip, 0);
        end
        stop = 1;
        tick();
        stop = 0;
        chk("stop_cv", chip_valid, 0);
        chk("stop_done", done, 0);
        chk("stop_ready", cfg_ready, 1);
        chk("stop_fase_held", fase, 4'b0010);
        tick();
        chk("stop_after", {chip_valid, done, busy}, 3'b000);

        // zero seed rejected
        do_reset();
        configure(4'b0000, 4'b0011, 5'd0, 8'd0);
        chk("zero_seed_err", {err, cfg_ready, busy}, 3'b110);
        tick();
        chk("zero_seed_err_clear", err, 0);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("zero_seed_idle_%0d", k), {chip_valid, busy, cfg_ready}, 3'b001);
            tick();
        end

        // lockup with taps=0 from seed 0001: the first step already empties the state
        configure(4'b0001, 4'b0000, 5'd0, 8'd0);
        pulse_start();
        tick();
        chk("lock1", status(), 11'b1_0_1_1_0_0_1_0000);
        tick();
        chk("lock1_after", {err, chip_valid}, 2'b00);
        pulse_start();
        tick();
        chk("lock1_idle", {busy, chip_valid}, 2'b00);

        // lockup from seed 1000: chips 0,0,0,1 with err on the 4th step
        configure(4'b1000, 4'b0000, 5'd0, 8'd0);
        pulse_start();
        tick();
        chk("lock4_s1", status(), 11'b0_1_1_0_0_0_0_0100);
        tick();
        chk("lock4_s2", status(), 11'b0_1_1_0_0_0_0_0010);
        tick();
        chk("lock4_s3", status(), 11'b0_1_1_0_0_0_0_0001);
        tick();
        chk("lock4_s4", status(), 11'b1_0_1_1_0_0_1_0000);
        pulse_start();
        tick();
        chk("lock4_idle", {busy, chip_valid}, 2'b00);

        // reset mid-run wins over concurrent config and stop
        configure(4'b0001, 4'b0011, 5'd0, 8'd0);
        pulse_start();
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1; cfg_valid = 1; cfg_seed = 4'b0101; stop = 1;
        tick();
        rst = 0; cfg_valid = 0; stop = 0;
        chk("rst_status", status(), 11'b1_0_0_0_0_0_0_0000);
        pulse_start();
        chk("rst_start_ignored", status(), 11'b1_0_0_0_0_0_0_0000);
        tick();
        chk("rst_start_ignored2", {busy, chip_valid}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
